// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and data ports onto one RAM (round-robin contention with MEM_ARBITER_RR_EN)
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  output logic        ierr,
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        derr,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic [1:0]  ram_state
);
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic dreq, ig, dg, live, acc, rerr, tmo, ok, bad, pick_d;
  assign dreq = dren | dwen;
  assign ig   = state == IGNT;
  assign dg   = state == DGNT;
  assign live = (ig & iren) | (dg & dreq);
  assign acc  = ram_state == 2'b10;
  assign rerr = ram_state == 2'b11;
  // the timeout fires on the TIMEOUT_CYCLES-th granted cycle that sees neither ACCESS nor ERROR
  assign tmo  = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1)) && !acc && !rerr;
  assign ok   = live & acc;
  assign bad  = live & (rerr | tmo);
`ifdef MEM_ARBITER_RR_EN
  logic last_d;
  assign pick_d = dreq & (~iren | ~last_d);
`else
  assign pick_d = dreq;
`endif
  // RAM side follows the live inputs of whoever holds the grant; strobes drop as soon as the request does
  always_comb begin
    ram_ren   = (ig & iren) | (dg & dren & ~dwen);
    ram_wen   = dg & dwen;
    ram_addr  = ig ? iaddr : dg ? daddr : '0;
    ram_store = dg ? dstore : '0;
    iload     = (ig & ok) ? ram_load : '0;
    dload     = (dg & ok) ? ram_load : '0;
    ierr      = ig & bad;
    derr      = dg & bad;
    iwait     = iren & ~(ig & (ok | bad));
    dwait     = dreq & ~(dg & (ok | bad));
  end
  // next grant: pick a requester from IDLE, always return to IDLE after a grant ends
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = pick_d ? DGNT : iren ? IGNT : IDLE;
    else if (!live || ok || bad) state_nx = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else state <= state_nx;
  end
  // granted-cycle age, zero whenever idle so every grant starts fresh
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt <= '0;
    else cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
  end
`ifdef MEM_ARBITER_RR_EN
  // remember which side was served last, updated whenever a grant ends
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) last_d <= 1'b0;
    else if (state != IDLE && state_nx == IDLE) last_d <= dg;
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int TMO = 4;
  logic        clk = 0, nrst = 0;
  logic        iren = 0, dren = 0, dwen = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ram_load = 0;
  logic [1:0]  ram_state = 0;
  logic [31:0] iload, dload, ram_addr, ram_store;
  logic        iwait, ierr, dwait, derr, ram_ren, ram_wen;
  int n_cmp = 0, n_bad = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .nrst(nrst), .iren(iren), .iaddr(iaddr), .iload(iload), .iwait(iwait), .ierr(ierr),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait), .derr(derr),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_state(ram_state)
  );

  always #5 clk = ~clk;

  // transaction model: owner 0 none / 1 fetch / 2 data, age = granted cycles already spent
  int owner = 0, age = 0, nx_owner = 0, nx_age = 0;
  bit last_d = 0, nx_last = 0, i_done = 0, d_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // compute what every output must be this cycle and compare, then work out the model's next cycle
  task automatic eval();
    bit ireq, dreq, live, acc, er, to, fin_ok, fin_er, pick_d;
    #2;
    if (!nrst) begin owner = 0; age = 0; last_d = 0; end
    ireq = iren;
    dreq = dren | dwen;
    live = (owner == 1) ? ireq : (owner == 2) ? dreq : 0;
    acc = ram_state == 2'b10;
    er = ram_state == 2'b11;
    to = (TMO != 0) && (age + 1 >= TMO) && !acc && !er;
    fin_ok = live && acc;
    fin_er = live && (er || to);
    chk("ram_ren", ram_ren, (owner == 1) ? ireq : (owner == 2) ? (dren && !dwen) : 0);
    chk("ram_wen", ram_wen, owner == 2 && dwen);
    chk("ram_addr", ram_addr, (owner == 1) ? iaddr : (owner == 2) ? daddr : 0);
    chk("ram_store", ram_store, (owner == 2) ? dstore : 0);
    chk("iload", iload, (owner == 1 && fin_ok) ? ram_load : 0);
    chk("dload", dload, (owner == 2 && fin_ok) ? ram_load : 0);
    chk("ierr", ierr, owner == 1 && fin_er);
    chk("derr", derr, owner == 2 && fin_er);
    chk("iwait", iwait, ireq && !(owner == 1 && (fin_ok || fin_er)));
    chk("dwait", dwait, dreq && !(owner == 2 && (fin_ok || fin_er)));
    i_done = owner == 1 && (fin_ok || fin_er);
    d_done = owner == 2 && (fin_ok || fin_er);
    nx_owner = owner; nx_age = age + 1; nx_last = last_d;
`ifdef MEM_ARBITER_RR_EN
    pick_d = dreq && (!ireq || !last_d);
`else
    pick_d = dreq;
`endif
    if (owner == 0) begin
      nx_owner = pick_d ? 2 : ireq ? 1 : 0;
      nx_age = 0;
    end else if (!live || fin_ok || fin_er) begin
      nx_owner = 0;
      nx_last = owner == 2;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (!nrst) begin owner = 0; age = 0; last_d = 0; end
    else begin owner = nx_owner; age = nx_age; last_d = nx_last; end
    @(negedge clk);
  endtask

  task automatic idle_all();
    iren = 0; dren = 0; dwen = 0; ram_state = 0; ram_load = 0;
  endtask

  initial begin
    int r;
    @(negedge clk);
    eval(); chk("rst_ren", ram_ren, 0); adv();
    eval(); adv();
    nrst = 1;
    // single fetch completing on the first grant cycle
    iren = 1; iaddr = 32'h100;
    eval(); chk("f_c0_ren", ram_ren, 0); chk("f_c0_iwait", iwait, 1); adv();
    ram_state = 2'b10; ram_load = 32'hDEADBEEF;
    eval(); chk("f_c1_ren", ram_ren, 1); chk("f_c1_iwait", iwait, 0); chk("f_c1_iload", iload, 32'hDEADBEEF); adv();
    idle_all();
    eval(); chk("f_c2_ren", ram_ren, 0); chk("f_c2_iload", iload, 0); adv();
    // write beats simultaneous read
    dwen = 1; dren = 1; daddr = 32'h1000; dstore = 32'h1; ram_state = 2'b01;
    eval(); adv();
    eval(); chk("w_wen", ram_wen, 1); chk("w_ren", ram_ren, 0); chk("w_addr", ram_addr, 32'h1000);
    chk("w_store", ram_store, 1); chk("w_dwait", dwait, 1); adv();
    ram_state = 2'b10;
    eval(); chk("w_done_dwait", dwait, 0); adv();
    idle_all(); eval(); adv();
    // stuck-busy data read times out on the 4th granted cycle
    dren = 1; daddr = 32'h2000; ram_state = 2'b01;
    eval(); adv();
    for (int k = 1; k <= TMO; k++) begin
      eval();
      chk("t_derr", derr, k == TMO);
      chk("t_dwait", dwait, k != TMO);
      adv();
    end
    dren = 0;
    eval(); chk("t_idle_ren", ram_ren, 0); adv();
    // fetch error pulse
    iren = 1; iaddr = 32'h300; ram_state = 2'b11;
    eval(); adv();
    eval(); chk("e_ierr", ierr, 1); chk("e_iwait", iwait, 0); adv();
    iren = 0;
    eval(); chk("e_ierr_off", ierr, 0); adv();
    // reset in the middle of a data grant
    dren = 1; daddr = 32'h4000; ram_state = 2'b01;
    eval(); adv();
    eval(); chk("r_ren_pre", ram_ren, 1);
    nrst = 0; #1;
    chk("r_ren", ram_ren, 0); chk("r_wen", ram_wen, 0); chk("r_addr", ram_addr, 0); chk("r_dwait", dwait, 1);
    adv();
    idle_all(); eval(); adv();
    nrst = 1;
    // continuous contention with immediate ACCESS
    iren = 1; dren = 1; iaddr = 32'hA0; daddr = 32'hD0; ram_state = 2'b10;
    for (int c = 0; c < 9; c++) begin
      eval();
`ifdef MEM_ARBITER_RR_EN
      if (c % 2 == 1) chk("c_addr", ram_addr, ((c / 2) % 2 == 0) ? 32'hD0 : 32'hA0);
`else
      chk("c_iwait", iwait, 1);
`endif
      adv();
    end
    idle_all(); eval(); adv();
    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      nrst = ($urandom % 150) != 0;
      if (!(iren && !i_done && ($urandom % 20) != 0)) begin
        iren = $urandom % 2; iaddr = $urandom;
      end
      if (!((dren || dwen) && !d_done && ($urandom % 20) != 0)) begin
        dren = $urandom % 2; dwen = ($urandom % 3) == 0; daddr = $urandom; dstore = $urandom;
      end
      r = $urandom % 20;
      ram_state = (r < 2) ? 2'b00 : (r < 13) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
      ram_load = $urandom;
      eval();
      adv();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
